// File: rtl/imem_loader.sv
// Boot loader: validates a framed byte stream from the UART and writes
// little-endian 32-bit words into the instruction RAM, holding the CPU in reset.
module imem_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              loading,
    output logic              done,
    output logic              err
);

    localparam logic [7:0]  SYNC     = 8'hA5;
    localparam logic [16:0] DEPTH    = 17'(2 ** ADDR_W);
    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t          r_state;
    state_t          w_nxt;
    logic [7:0]      r_cnt_lo;
    logic [15:0]     r_n;
    logic [15:0]     r_widx;
    logic [1:0]      r_bidx;
    logic [31:0]     r_word;
    logic [7:0]      r_csum;
    logic [TW-1:0]   r_tmo;

    logic [15:0]     w_n;
    logic [31:0]     w_word;
    logic            w_in_frame;
    logic            w_last_word;

    assign w_n         = {rx_data, r_cnt_lo};
    // Bytes enter at the top so byte 0 ends up in bits [7:0] after four shifts
    assign w_word      = {rx_data, r_word[31:8]};
    assign w_in_frame  = (r_state == ST_CNT_LO) || (r_state == ST_CNT_HI) ||
                         (r_state == ST_DATA)   || (r_state == ST_CSUM);
    assign w_last_word = (r_bidx == 2'd3) && (r_widx == r_n - 16'd1);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (rx_valid && rx_data == SYNC) w_nxt = ST_CNT_LO;
            end
            ST_CNT_LO: begin
                if (rx_valid) w_nxt = ST_CNT_HI;
            end
            ST_CNT_HI: begin
                if (rx_valid) begin
                    if ({1'b0, w_n} > DEPTH) w_nxt = ST_ERR;
                    else if (w_n == 16'd0)   w_nxt = ST_CSUM;
                    else                     w_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_valid && w_last_word) w_nxt = ST_CSUM;
            end
            ST_CSUM: begin
                if (rx_valid) w_nxt = (rx_data == r_csum) ? ST_DONE : ST_ERR;
            end
            default: w_nxt = ST_IDLE;
        endcase
        if (w_in_frame && !rx_valid && r_tmo == TMO_LAST) w_nxt = ST_ERR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt_lo  <= '0;
            r_n       <= '0;
            r_widx    <= '0;
            r_bidx    <= '0;
            r_word    <= '0;
            r_csum    <= '0;
            r_tmo     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_reset <= 1'b0;
            loading   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            mem_we    <= 1'b0;
            loading   <= (w_nxt == ST_CNT_LO) || (w_nxt == ST_CNT_HI) ||
                         (w_nxt == ST_DATA)   || (w_nxt == ST_CSUM);
            cpu_reset <= (w_nxt != ST_IDLE) && (w_nxt != ST_DONE);
            done      <= (w_nxt == ST_DONE);
            err       <= (w_nxt == ST_ERR);

            if (w_in_frame && !rx_valid) r_tmo <= r_tmo + 1'b1;
            else                         r_tmo <= '0;

            if (rx_valid) begin
                case (r_state)
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        if (rx_data == SYNC) begin
                            r_csum <= '0;
                            r_bidx <= '0;
                            r_widx <= '0;
                        end
                    end
                    ST_CNT_LO: r_cnt_lo <= rx_data;
                    ST_CNT_HI: r_n      <= w_n;
                    ST_DATA: begin
                        r_word <= w_word;
                        r_csum <= r_csum ^ rx_data;
                        r_bidx <= r_bidx + 2'd1;
                        if (r_bidx == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= ADDR_W'(r_widx);
                            mem_wdata <= w_word;
                            r_widx    <= r_widx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
